// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
//
// Shared definitions for the MLP result sink:
//   DATA_W       - width of one result word (signed Q6.9)
//   FRAC_W       - fractional bits of a result word
//   CLASS_IDX_W  - width of the reported class index
//   sink_state_e - frame-tracking states of the sink
//   relu_clamp() - clamps a negative result word to zero
// -----------------------------------------------------------------------------
package mlp_pkg;

  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 9;
  localparam int CLASS_IDX_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } sink_state_e;

  // Two's complement word: the sign bit alone decides whether it is negative.
  function automatic logic [DATA_W-1:0] relu_clamp(input logic [DATA_W-1:0] word);
    return word[DATA_W-1] ? '0 : word;
  endfunction

endpackage

// File: rtl/mlp_sync_fifo.sv
// -----------------------------------------------------------------------------
// mlp_sync_fifo
//
// Single-clock FIFO with a valid/ready read side and a fire-and-forget write
// side. A push while full is accepted only when a pop happens in the same
// cycle; otherwise the word is ignored and the caller flags the drop.
//
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset (empties the FIFO)
//   clear_i  - synchronous flush
//   push_i   - write request, data_i is the word to store
//   pop_i    - read acknowledge (honoured only when valid_o is high)
//   data_o   - head word, zero while empty
//   valid_o  - FIFO holds at least one word
//   full_o   - FIFO holds DEPTH words
// -----------------------------------------------------------------------------
module mlp_sync_fifo
  import mlp_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full and empty are distinct
  // even though the low bits are equal in both cases.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic empty;
  logic do_push;
  logic do_pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_pop  = pop_i && !empty;
  // When full, the slot being written is the one the pop frees this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  assign valid_o = !empty;
  // Zero while empty keeps the output defined after reset without having to
  // reset the storage array.
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mlp_result_sink.sv
// -----------------------------------------------------------------------------
// mlp_result_sink
//
// Collects NUM_OUT signed Q6.9 result words per inference frame, reports the
// argmax (lowest index wins a tie) through a valid/ready handshake, and
// forwards every accepted word through an output FIFO.
//
// Optional feature: define MLP_SINK_RELU_EN to clamp negative words to zero
// before they reach both the FIFO and the argmax.
//
// Ports:
//   clk_i, rst_ni               - clock, asynchronous active-low reset
//   clear_i                     - synchronous flush of FIFO, frame and flags
//   result_valid_i/payload_i    - incoming result word, no backpressure
//   out_valid_o/ready_i/payload_o - FIFO read handshake
//   class_valid_o/ready_i       - argmax report handshake
//   class_idx_o/class_val_o     - winning index and its value
//   overflow_o                  - sticky: word dropped on a full FIFO
//   frame_err_o                 - sticky: word arrived while reporting
// -----------------------------------------------------------------------------
module mlp_result_sink
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_OUT    = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   result_valid_i,
  input  logic [DATA_W-1:0]      result_payload_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_payload_o,
  output logic                   class_valid_o,
  input  logic                   class_ready_i,
  output logic [CLASS_IDX_W-1:0] class_idx_o,
  output logic [DATA_W-1:0]      class_val_o,
  output logic                   overflow_o,
  output logic                   frame_err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_OUT + 1);

  sink_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      max_q, max_d;
  logic [CLASS_IDX_W-1:0] argidx_q, argidx_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  logic [DATA_W-1:0]      word;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   out_pop;
  logic                   drop;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
`ifdef MLP_SINK_RELU_EN
  assign word = relu_clamp(result_payload_i);
`else
  assign word = result_payload_i;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  // A flush wins over a word arriving in the same cycle.
  assign fifo_push = result_valid_i && !clear_i;
  assign out_pop   = out_valid_o && out_ready_i;
  assign drop      = fifo_push && fifo_full && !out_pop;

  mlp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (word),
    .pop_i   (out_pop),
    .data_o  (out_payload_o),
    .valid_o (out_valid_o),
    .full_o  (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM and argmax
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    max_d    = max_q;
    argidx_d = argidx_q;

    if (clear_i) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      max_d    = '0;
      argidx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (result_valid_i) begin
            idx_d    = IDX_W'(1);
            max_d    = word;
            argidx_d = '0;
            state_d  = (IDX_W'(1) == IDX_W'(NUM_OUT)) ? S_REPORT : S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (result_valid_i) begin
            // Strict greater-than keeps the earliest index on a tie.
            if ($signed(word) > $signed(max_q)) begin
              max_d    = word;
              argidx_d = CLASS_IDX_W'(idx_q);
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_OUT - 1)) state_d = S_REPORT;
          end
        end

        S_REPORT: begin
          // Late words go only to the FIFO; the report stays frozen.
          if (class_ready_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d  = overflow_q | drop;
    frame_err_d = frame_err_q | (result_valid_i && (state_q == S_REPORT));
    if (clear_i) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      max_q       <= '0;
      argidx_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      argidx_q    <= argidx_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign class_valid_o = (state_q == S_REPORT);
  assign class_idx_o   = argidx_q;
  assign class_val_o   = max_q;
  assign overflow_o    = overflow_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_mlp_result_sink.sv
// -----------------------------------------------------------------------------
// tb_mlp_result_sink
//
// Directed bench for mlp_result_sink with NUM_OUT=10 and FIFO_DEPTH=16.
// Inputs change on the falling clock edge; outputs are sampled there too,
// half a cycle away from the rising edge that updates the design.
// -----------------------------------------------------------------------------
module tb_mlp_result_sink;

  localparam int NUM_OUT    = 10;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        result_valid = 1'b0;
  logic [15:0] result_payload = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_payload;
  logic        class_valid;
  logic        class_ready = 1'b0;
  logic [7:0]  class_idx;
  logic [15:0] class_val;
  logic        overflow;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] frame_w [NUM_OUT];

  mlp_result_sink #(
    .NUM_OUT    (NUM_OUT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .result_valid_i   (result_valid),
    .result_payload_i (result_payload),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_payload_o    (out_payload),
    .class_valid_o    (class_valid),
    .class_ready_i    (class_ready),
    .class_idx_o      (class_idx),
    .class_val_o      (class_val),
    .overflow_o       (overflow),
    .frame_err_o      (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives frame_w; the last word is left on the bus, not yet captured.
  task automatic send_frame();
    for (int i = 0; i < NUM_OUT; i++) begin
      @(negedge clk);
      result_valid   = 1'b1;
      result_payload = frame_w[i];
    end
  endtask

  task automatic end_frame_check(input string tag, input logic [7:0] exp_idx,
                                 input logic [15:0] exp_val);
    check({tag, "_valid_before"}, class_valid, 1'b0);
    @(negedge clk);
    result_valid = 1'b0;
    check({tag, "_valid_after"}, class_valid, 1'b1);
    check({tag, "_idx"}, class_idx, exp_idx);
    check({tag, "_val"}, class_val, exp_val);
  endtask

  task automatic ack_class(input string tag);
    @(negedge clk);
    class_ready = 1'b1;
    @(negedge clk);
    class_ready = 1'b0;
    check({tag, "_ack_idle"}, class_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_payload"}, out_payload, 16'h0);
    check({tag, "_class_valid"}, class_valid, 1'b0);
    check({tag, "_class_idx"}, class_idx, 8'h0);
    check({tag, "_class_val"}, class_val, 16'h0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  task automatic load_frame_a();
    for (int i = 0; i < NUM_OUT; i++) frame_w[i] = 16'h0010 + 16'(i);
    frame_w[3] = 16'h0200;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- frame A: max 0x0200 at index 3 ----------------
    load_frame_a();
    for (int i = 0; i < NUM_OUT; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("a_first_visible", out_valid, 1'b1);
        check("a_first_payload", out_payload, 16'h0010);
      end
      result_valid   = 1'b1;
      result_payload = frame_w[i];
      if (i == 0) check("a_no_bypass", out_valid, 1'b0);
    end
    end_frame_check("a", 8'd3, 16'h0200);
    check("a_frame_err", frame_err, 1'b0);
    ack_class("a");

    // ---------------- tie: 0x0100 at indices 2 and 7 ----------------
    for (int i = 0; i < NUM_OUT; i++) frame_w[i] = 16'h0005;
    frame_w[2] = 16'h0100;
    frame_w[7] = 16'h0100;
    send_frame();
    end_frame_check("tie", 8'd2, 16'h0100);

    // ---------------- word during REPORT, class_ready low for 5 cycles -----
    @(negedge clk);
    @(negedge clk);
    check("rep_fifo_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    result_valid   = 1'b1;
    result_payload = 16'h1234;
    @(negedge clk);
    result_valid = 1'b0;
    check("rep_frame_err", frame_err, 1'b1);
    check("rep_word_in_fifo", out_valid, 1'b1);
    check("rep_word_payload", out_payload, 16'h1234);
    check("rep_class_valid", class_valid, 1'b1);
    check("rep_class_idx", class_idx, 8'd2);
    check("rep_class_val", class_val, 16'h0100);
    @(negedge clk);
    ack_class("rep");
    out_ready = 1'b1;
    @(negedge clk);
    check("rep_word_popped", out_valid, 1'b0);

    // ---------------- clear wins over a simultaneous word ----------------
    @(negedge clk);
    clear          = 1'b1;
    result_valid   = 1'b1;
    result_payload = 16'h7777;
    @(negedge clk);
    clear        = 1'b0;
    result_valid = 1'b0;
    check("clr_frame_err", frame_err, 1'b0);
    check("clr_no_push", out_valid, 1'b0);
    check("clr_class_valid", class_valid, 1'b0);

    // ---------------- all-negative frame, 0xFF00 largest at index 5 --------
    for (int i = 0; i < NUM_OUT; i++) frame_w[i] = 16'h8000 + 16'(i * 16'h0100);
    frame_w[5] = 16'hFF00;
    send_frame();
`ifdef MLP_SINK_RELU_EN
    end_frame_check("neg", 8'd0, 16'h0000);
`else
    end_frame_check("neg", 8'd5, 16'hFF00);
`endif
    ack_class("neg");
    @(negedge clk);

    // ---------------- overflow: 17 words into a 16-deep FIFO ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) check("ovf_not_yet", overflow, 1'b0);
      result_valid   = 1'b1;
      result_payload = 16'h0100 + 16'(i);
    end
    @(negedge clk);
    result_valid = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_frame_err", frame_err, 1'b1);
    check("ovf_class_idx", class_idx, 8'd9);
    check("ovf_class_val", class_val, 16'h0109);
    // Pop the head while pushing one more word into the full FIFO.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic [15:0] exp_w;
      exp_w = (i == 16) ? 16'h0AAA : 16'h0100 + 16'(i);
      check($sformatf("ovf_rd%0d_valid", i), out_valid, 1'b1);
      check($sformatf("ovf_rd%0d_data", i), out_payload, exp_w);
      if (i == 0) begin
        result_valid   = 1'b1;
        result_payload = 16'h0AAA;
      end else begin
        result_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("ovf_drained", out_valid, 1'b0);
    ack_class("ovf");

    // ---------------- reset in the middle of a frame ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      result_valid   = 1'b1;
      result_payload = 16'h0300 + 16'(i);
    end
    @(negedge clk);
    result_valid = 1'b0;
    check("mid_fifo_holds", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_fifo_discarded", out_valid, 1'b0);
    load_frame_a();
    send_frame();
    end_frame_check("post_rst", 8'd3, 16'h0200);
    ack_class("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
